// File: rtl/bs_pkg.sv
// Shared types and helpers for the packet bus generator/arbiter.
package bs_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP     = 2'd1,
    DELIVER = 2'd2
  } state_e;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  localparam int DROP_CNT_W = 16;
  localparam int PKT_MAX_W  = 1024;
  localparam int ID_MAX_W   = 64;

  // Header ID sits in the top id_w bits of a pckg_sz-bit packet.
  function automatic logic [ID_MAX_W-1:0] hdr_id(input logic [PKT_MAX_W-1:0] pkt,
                                                 input int pckg_sz,
                                                 input int id_w);
    logic [PKT_MAX_W-1:0] shifted;
    logic [ID_MAX_W-1:0]  mask;
    shifted = pkt >> (pckg_sz - id_w);
    mask    = (id_w >= ID_MAX_W) ? '1 : ((ID_MAX_W'(1) << id_w) - ID_MAX_W'(1));
    return shifted[ID_MAX_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/bs_gnrtr_n_rbtr_fc_arb.sv
// Combinational winner select: round-robin from ptr upward, or lowest index.
module bs_rr_arbiter
  import bs_pkg::*;
#(
  parameter int DRVRS    = 8,
  parameter int ARB_MODE = 0,
  localparam int IDX_W   = $clog2(DRVRS)
) (
  input  logic [DRVRS-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any_req
);

  logic found;
  int   idx;

  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < DRVRS; k++) begin
      idx = (ARB_MODE == int'(ARB_FIXED)) ? k : ((int'(ptr) + k) % DRVRS);
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = IDX_W'(idx);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/bs_gnrtr_n_rbtr_fc.sv
// Packet bus arbiter: grants one driver, pops its head packet and routes it
// to one destination or broadcasts it, with backpressure, timeout and drop count.
//
//   state   | meaning
//   IDLE    | waiting for any pndng; latches winner packet on exit
//   POP     | pop strobe to winner; header ID decoded, invalid IDs dropped
//   DELIVER | wait for targets not full, push once, or drop on timeout
module bs_gnrtr_n_rbtr_fc
  import bs_pkg::*;
#(
  parameter int              PCKG_SZ  = 16,
  parameter int              DRVRS    = 8,
  parameter int              ID_W     = 8,
  parameter logic [ID_W-1:0] BCAST_ID = 8'hFF,
  parameter int              ARB_MODE = 0,
  parameter int              TIMEOUT  = 16,
  localparam int             IDX_W    = $clog2(DRVRS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DRVRS-1:0]                pndng,
  input  logic [DRVRS-1:0][PCKG_SZ-1:0]   D_pop,
  output logic [DRVRS-1:0]                pop,
  input  logic [DRVRS-1:0]                full,
  output logic [DRVRS-1:0]                push,
  output logic [DRVRS-1:0][PCKG_SZ-1:0]   D_push,
  output logic                            busy,
  output logic [IDX_W-1:0]                gnt_id,
  output logic [DROP_CNT_W-1:0]           drop_cnt
);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_POP     = POP;
  localparam logic [1:0] S_DELIVER = DELIVER;

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int CMP_W  = ((ID_W > 32) ? ID_W : 32) + 1;

  logic [1:0]            state;
  logic [PCKG_SZ-1:0]    pkt;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      dest_idx;
  logic                  bcast;
  logic [WAIT_W-1:0]     wait_cnt;

  logic [IDX_W-1:0]      arb_idx;
  logic                  any_req;
  logic [ID_W-1:0]       dest_id;
  logic                  dest_bcast;
  logic                  dest_uni;
  logic [DRVRS-1:0]      src_mask;
  logic [DRVRS-1:0]      tgt_mask;
  logic                  tgt_clear;
  logic                  timed_out;
  logic [IDX_W-1:0]      ptr_next;
  logic [DROP_CNT_W-1:0] drop_next;

  bs_rr_arbiter #(
    .DRVRS    (DRVRS),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .req     (pndng),
    .ptr     (ptr),
    .gnt_idx (arb_idx),
    .any_req (any_req)
  );

  assign dest_id    = ID_W'(hdr_id(PKT_MAX_W'(pkt), PCKG_SZ, ID_W));
  assign dest_bcast = (dest_id == BCAST_ID);
  assign dest_uni   = (CMP_W'(dest_id) < CMP_W'(DRVRS));

  // Broadcast targets every lane except the source; full on the source is ignored.
  assign src_mask  = DRVRS'(1) << gnt_id;
  assign tgt_mask  = bcast ? ~src_mask : (DRVRS'(1) << dest_idx);
  assign tgt_clear = ((full & tgt_mask) == '0);
  assign timed_out = !tgt_clear && (int'(wait_cnt) >= TIMEOUT - 1);

  assign ptr_next  = (int'(gnt_id) == DRVRS - 1) ? '0 : gnt_id + 1'b1;
  assign drop_next = (&drop_cnt) ? drop_cnt : drop_cnt + 1'b1;

  assign pop    = (state == S_POP) ? src_mask : '0;
  assign push   = ((state == S_DELIVER) && tgt_clear) ? tgt_mask : '0;
  assign D_push = {DRVRS{pkt}};
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      pkt      <= '0;
      gnt_id   <= '0;
      ptr      <= '0;
      dest_idx <= '0;
      bcast    <= 1'b0;
      wait_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            pkt    <= D_pop[arb_idx];
            gnt_id <= arb_idx;
            state  <= S_POP;
          end
        end
        S_POP: begin
          if (dest_bcast || dest_uni) begin
            dest_idx <= IDX_W'(dest_id);
            bcast    <= dest_bcast;
            wait_cnt <= '0;
            state    <= S_DELIVER;
          end else begin
            drop_cnt <= drop_next;
            ptr      <= ptr_next;
            state    <= S_IDLE;
          end
        end
        S_DELIVER: begin
          if (tgt_clear) begin
            ptr   <= ptr_next;
            state <= S_IDLE;
          end else if (timed_out) begin
            drop_cnt <= drop_next;
            ptr      <= ptr_next;
            state    <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr_fc.sv
// Directed bench for the packet bus arbiter with a transaction-level reference model.
module tb_bs_gnrtr_n_rbtr_fc;

  localparam int N   = 8;
  localparam int W   = 16;
  localparam int TMO = 16;

  logic              clk   = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      pndng = '0;
  logic [N-1:0]      full  = '0;
  logic [N-1:0][W-1:0] d_pop = '0;

  logic [N-1:0]        pop, push, pop_fp, push_fp;
  logic [N-1:0][W-1:0] d_push, d_push_fp;
  logic                busy, busy_fp;
  logic [2:0]          gnt_id, gnt_id_fp;
  logic [15:0]         drop_cnt, drop_cnt_fp;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bs_gnrtr_n_rbtr_fc #(.PCKG_SZ(W), .DRVRS(N), .ID_W(8), .BCAST_ID(8'hFF),
                       .ARB_MODE(0), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .pop(pop),
    .full(full), .push(push), .D_push(d_push), .busy(busy),
    .gnt_id(gnt_id), .drop_cnt(drop_cnt));

  bs_gnrtr_n_rbtr_fc #(.PCKG_SZ(W), .DRVRS(N), .ID_W(8), .BCAST_ID(8'hFF),
                       .ARB_MODE(1), .TIMEOUT(TMO)) dut_fp (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .pop(pop_fp),
    .full(full), .push(push_fp), .D_push(d_push_fp), .busy(busy_fp),
    .gnt_id(gnt_id_fp), .drop_cnt(drop_cnt_fp));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a packet is either absent, being popped, or waiting to be delivered.
  int           m_stage  = 0;
  int           m_src    = 0;
  int           m_ptr    = 0;
  int           m_waited = 0;
  int           m_drops  = 0;
  int           m_k      = 0;
  int           m_dest   = 0;
  logic [W-1:0] m_pkt    = '0;

  function automatic logic [N-1:0] m_targets();
    int d;
    d = int'(m_pkt[15:8]);
    if (d == 255) return ~(N'(1) << m_src);
    return N'(1) << d;
  endfunction

  task automatic m_finish(input bit dropped);
    if (dropped && m_drops < 65535) m_drops++;
    m_ptr   = (m_src + 1) % N;
    m_stage = 0;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_stage = 0; m_src = 0; m_ptr = 0; m_waited = 0; m_drops = 0; m_pkt = '0;
    end else if (m_stage == 0) begin
      if (pndng != '0) begin
        m_k = 0;
        while (!pndng[(m_ptr + m_k) % N]) m_k++;
        m_src   = (m_ptr + m_k) % N;
        m_pkt   = d_pop[m_src];
        m_stage = 1;
      end
    end else if (m_stage == 1) begin
      m_dest = int'(m_pkt[15:8]);
      if (m_dest < N || m_dest == 255) begin
        m_waited = 0;
        m_stage  = 2;
      end else begin
        m_finish(1'b1);
      end
    end else begin
      if ((full & m_targets()) == '0) m_finish(1'b0);
      else begin
        m_waited++;
        if (m_waited == TMO) m_finish(1'b1);
      end
    end
  end

  logic [N-1:0] e_pop, e_push;

  always @(negedge clk) begin
    if (chk_en) begin
      e_pop  = (m_stage == 1) ? (N'(1) << m_src) : '0;
      e_push = (m_stage == 2 && (full & m_targets()) == '0) ? m_targets() : '0;
      check("cmp_pop", pop, e_pop);
      check("cmp_push", push, e_push);
      check("cmp_busy", busy, m_stage != 0);
      check("cmp_gnt", gnt_id, m_src);
      check("cmp_drop", drop_cnt, m_drops);
      for (int j = 0; j < N; j++)
        if (e_push[j]) check($sformatf("cmp_data%0d", j), d_push[j], m_pkt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pop(input int src);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (pop[src]) seen = 1'b1;
    end
    if (!seen) check($sformatf("wait_pop%0d", src), 0, 1);
  endtask

  task automatic wait_any_pop(output logic [N-1:0] seen);
    seen = '0;
    for (int i = 0; i < 40 && seen == '0; i++) begin
      @(negedge clk);
      seen = pop;
    end
    if (seen == '0) check("wait_any_pop", 0, 1);
  endtask

  int           rr_exp [6] = '{0, 1, 3, 0, 1, 3};
  int           got;
  int           pushes;
  logic [N-1:0] seen_pop;

  initial begin
    #1 reset = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_pop", pop, 0);
    check("rst_push", push, 0);
    check("rst_gnt", gnt_id, 0);
    check("rst_drop", drop_cnt, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // fairness: three drivers held pending, all addressed to 6
    d_pop[0] = 16'h0600; d_pop[1] = 16'h0611; d_pop[3] = 16'h0633;
    pndng = 8'b0000_1011;
    for (int g = 0; g < 6; g++) begin
      got = -1;
      for (int i = 0; i < 20 && got < 0; i++) begin
        @(negedge clk);
        if (pop != '0) got = int'(gnt_id);
      end
      check($sformatf("rr_grant%0d", g), got, rr_exp[g]);
      check($sformatf("fp_pop%0d", g), pop_fp, 8'b0000_0001);
    end
    tick(); pndng = '0;
    repeat (3) tick();

    // unicast 2 -> 5
    d_pop[2] = 16'h0537; pndng = 8'b0000_0100;
    @(negedge clk); check("uni_pre_pop", pop, 0);
    tick(); @(negedge clk); check("uni_pop", pop, 8'b0000_0100);
    tick(); pndng = '0;
    @(negedge clk);
    check("uni_push", push, 8'b0010_0000);
    check("uni_data", d_push[5], 16'h0537);
    tick(); @(negedge clk); check("uni_idle", busy, 0);

    // broadcast from 4, source lane full must not block
    d_pop[4] = 16'hFFAA; full = 8'b0001_0000; pndng = 8'b0001_0000;
    wait_pop(4);
    tick(); pndng = '0;
    @(negedge clk);
    check("bc_push", push, 8'b1110_1111);
    check("bc_data", d_push[0], 16'hFFAA);
    tick(); full = '0;

    // broadcast held off by full[1] for exactly three cycles
    d_pop[4] = 16'hFF55; full = 8'b0000_0010; pndng = 8'b0001_0000;
    wait_pop(4);
    tick(); pndng = '0;
    @(negedge clk); check("bc2_blk0", push, 0);
    tick(); @(negedge clk); check("bc2_blk1", push, 0);
    tick(); @(negedge clk); check("bc2_blk2", push, 0);
    tick(); full = '0;
    @(negedge clk); check("bc2_push", push, 8'b1110_1111);
    tick();

    // timeout on unicast to 3
    d_pop[0] = 16'h0301; full = 8'b0000_1000; pndng = 8'b0000_0001;
    wait_pop(0);
    tick(); pndng = '0;
    pushes = 0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (push != '0) pushes++;
      if (i == TMO - 1) check("tmo_busy_last", busy, 1);
      tick();
    end
    @(negedge clk);
    check("tmo_pushes", pushes, 0);
    check("tmo_idle", busy, 0);
    check("tmo_drop", drop_cnt, 1);
    full = '0;
    // pointer moved past 0, so driver 1 wins over driver 0
    d_pop[0] = 16'h0200; d_pop[1] = 16'h0211; pndng = 8'b0000_0011;
    wait_any_pop(seen_pop);
    check("tmo_ptr_adv", seen_pop, 8'b0000_0010);
    tick(); pndng = 8'b0000_0001;
    wait_pop(0);
    tick(); pndng = '0;
    repeat (2) tick();

    // invalid ID 0x09 dropped in POP, next grant right after
    d_pop[2] = 16'h0922; d_pop[5] = 16'h0155; pndng = 8'b0010_0100;
    wait_pop(2);
    check("inv_pop", pop, 8'b0000_0100);
    tick(); pndng = 8'b0010_0000;
    @(negedge clk);
    check("inv_push", push, 0);
    check("inv_idle", busy, 0);
    check("inv_drop", drop_cnt, 2);
    tick(); @(negedge clk); check("inv_next", pop, 8'b0010_0000);
    tick(); pndng = '0;
    repeat (2) tick();

    // asynchronous reset during a blocked unicast
    d_pop[6] = 16'h0366; full = 8'b0000_1000; pndng = 8'b0100_0000;
    wait_pop(6);
    tick(); pndng = '0;
    @(negedge clk); check("ar_busy_pre", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_pop", pop, 0);
    check("ar_push", push, 0);
    check("ar_gnt", gnt_id, 0);
    check("ar_drop", drop_cnt, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    full = '0;
    d_pop[0] = 16'h0100; d_pop[7] = 16'h0177; pndng = 8'b1000_0001;
    wait_any_pop(seen_pop);
    check("ar_next", seen_pop, 8'b0000_0001);
    tick(); pndng = 8'b1000_0000;
    wait_pop(7);
    tick(); pndng = '0;
    repeat (3) tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
